// File: rtl/periph_tl_buffer_pkg.sv
// Shared TL-UL opcode constants, default beat layouts and payload width helpers
// for the peripheral TL-UL buffer.
package periph_tl_buffer_pkg;

  localparam logic [2:0] TL_A_PUT_FULL        = 3'd0;
  localparam logic [2:0] TL_A_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] TL_A_GET             = 3'd4;
  localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

  localparam int TL_ADDR_W = 9;
  localparam int TL_DATA_W = 32;
  localparam int TL_SRC_W  = 2;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [2:0]             param;
    logic [1:0]             size;
    logic [TL_SRC_W-1:0]    source;
    logic [TL_ADDR_W-1:0]   address;
    logic [TL_DATA_W/8-1:0] mask;
    logic [TL_DATA_W-1:0]   data;
    logic                   corrupt;
  } tl_a_beat_t;

  typedef struct packed {
    logic [2:0]           opcode;
    logic [1:0]           param;
    logic [1:0]           size;
    logic [TL_SRC_W-1:0]  source;
    logic                 denied;
    logic                 corrupt;
    logic [TL_DATA_W-1:0] data;
  } tl_d_beat_t;

  // Flattened widths follow the field order of the structs above.
  function automatic int a_payload_w(input int addr_w, input int data_w, input int src_w);
    return 3 + 3 + 2 + src_w + addr_w + data_w / 8 + data_w + 1;
  endfunction

  function automatic int d_payload_w(input int data_w, input int src_w);
    return 3 + 2 + 2 + src_w + 1 + 1 + data_w;
  endfunction

endpackage

// File: rtl/periph_tl_queue.sv
// Generic valid/ready FIFO of DEPTH entries with occupancy output; no
// pass-through, so in_ready depends only on the stored level.
module periph_tl_queue
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  // Explicit wrap keeps non-power-of-two depths inside the storage array.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (level != FULL_LVL);
  assign out_valid = (level != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Storage carries no reset; only the bookkeeping below is cleared.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/periph_tl_buffer.sv
// TL-UL peripheral buffer: independent A and D channel FIFOs between the
// crossbar and a downstream slave, with no field translation.
module periph_tl_buffer
  import periph_tl_buffer_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int SRC_W  = 2,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_in_valid,
  output logic                a_in_ready,
  input  logic [2:0]          a_in_opcode,
  input  logic [2:0]          a_in_param,
  input  logic [1:0]          a_in_size,
  input  logic [SRC_W-1:0]    a_in_source,
  input  logic [ADDR_W-1:0]   a_in_address,
  input  logic [DATA_W/8-1:0] a_in_mask,
  input  logic [DATA_W-1:0]   a_in_data,
  input  logic                a_in_corrupt,
  output logic                a_out_valid,
  input  logic                a_out_ready,
  output logic [2:0]          a_out_opcode,
  output logic [2:0]          a_out_param,
  output logic [1:0]          a_out_size,
  output logic [SRC_W-1:0]    a_out_source,
  output logic [ADDR_W-1:0]   a_out_address,
  output logic [DATA_W/8-1:0] a_out_mask,
  output logic [DATA_W-1:0]   a_out_data,
  output logic                a_out_corrupt,
  input  logic                d_in_valid,
  output logic                d_in_ready,
  input  logic [2:0]          d_in_opcode,
  input  logic [1:0]          d_in_param,
  input  logic [1:0]          d_in_size,
  input  logic [SRC_W-1:0]    d_in_source,
  input  logic                d_in_denied,
  input  logic                d_in_corrupt,
  input  logic [DATA_W-1:0]   d_in_data,
  output logic                d_out_valid,
  input  logic                d_out_ready,
  output logic [2:0]          d_out_opcode,
  output logic [1:0]          d_out_param,
  output logic [1:0]          d_out_size,
  output logic [SRC_W-1:0]    d_out_source,
  output logic                d_out_denied,
  output logic                d_out_corrupt,
  output logic [DATA_W-1:0]   d_out_data,
  output logic [LVL_W-1:0]    a_level,
  output logic [LVL_W-1:0]    d_level
);

  localparam int A_W = a_payload_w(ADDR_W, DATA_W, SRC_W);
  localparam int D_W = d_payload_w(DATA_W, SRC_W);

  logic [A_W-1:0] a_in_payload;
  logic [A_W-1:0] a_out_payload;
  logic [D_W-1:0] d_in_payload;
  logic [D_W-1:0] d_out_payload;

  assign a_in_payload = {a_in_opcode, a_in_param, a_in_size, a_in_source,
                         a_in_address, a_in_mask, a_in_data, a_in_corrupt};
  assign {a_out_opcode, a_out_param, a_out_size, a_out_source,
          a_out_address, a_out_mask, a_out_data, a_out_corrupt} = a_out_payload;

  assign d_in_payload = {d_in_opcode, d_in_param, d_in_size, d_in_source,
                         d_in_denied, d_in_corrupt, d_in_data};
  assign {d_out_opcode, d_out_param, d_out_size, d_out_source,
          d_out_denied, d_out_corrupt, d_out_data} = d_out_payload;

  periph_tl_queue #(.DEPTH(DEPTH), .WIDTH(A_W)) u_a_queue (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_payload),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_payload),
    .level     (a_level)
  );

  periph_tl_queue #(.DEPTH(DEPTH), .WIDTH(D_W)) u_d_queue (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (d_in_valid),
    .in_ready  (d_in_ready),
    .in_data   (d_in_payload),
    .out_valid (d_out_valid),
    .out_ready (d_out_ready),
    .out_data  (d_out_payload),
    .level     (d_level)
  );

endmodule

// File: tb/tb_periph_tl_buffer.sv
// Directed and random checks for periph_tl_buffer: a DEPTH=2 instance for the
// table and reset sequences, a DEPTH=3 instance for the scoreboard stress.
module tb_periph_tl_buffer;
  import periph_tl_buffer_pkg::*;

  localparam int BEATS     = 10000;
  localparam int MAX_CYCLE = 60000;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;

  // DEPTH=2 instance
  tl_a_beat_t a_in, a_out;
  tl_d_beat_t d_in, d_out;
  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic d_in_valid, d_in_ready, d_out_valid, d_out_ready;
  logic [2:0] a_out_opcode, a_out_param, d_out_opcode;
  logic [1:0] a_out_size, a_out_source, d_out_param, d_out_size, d_out_source;
  logic [8:0] a_out_address;
  logic [3:0] a_out_mask;
  logic [31:0] a_out_data, d_out_data;
  logic a_out_corrupt, d_out_denied, d_out_corrupt;
  logic [1:0] a_level, d_level;

  assign a_out = {a_out_opcode, a_out_param, a_out_size, a_out_source,
                  a_out_address, a_out_mask, a_out_data, a_out_corrupt};
  assign d_out = {d_out_opcode, d_out_param, d_out_size, d_out_source,
                  d_out_denied, d_out_corrupt, d_out_data};

  periph_tl_buffer #(.DEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .a_in_valid(a_in_valid), .a_in_ready(a_in_ready),
    .a_in_opcode(a_in.opcode), .a_in_param(a_in.param), .a_in_size(a_in.size),
    .a_in_source(a_in.source), .a_in_address(a_in.address), .a_in_mask(a_in.mask),
    .a_in_data(a_in.data), .a_in_corrupt(a_in.corrupt),
    .a_out_valid(a_out_valid), .a_out_ready(a_out_ready),
    .a_out_opcode(a_out_opcode), .a_out_param(a_out_param), .a_out_size(a_out_size),
    .a_out_source(a_out_source), .a_out_address(a_out_address), .a_out_mask(a_out_mask),
    .a_out_data(a_out_data), .a_out_corrupt(a_out_corrupt),
    .d_in_valid(d_in_valid), .d_in_ready(d_in_ready),
    .d_in_opcode(d_in.opcode), .d_in_param(d_in.param), .d_in_size(d_in.size),
    .d_in_source(d_in.source), .d_in_denied(d_in.denied), .d_in_corrupt(d_in.corrupt),
    .d_in_data(d_in.data),
    .d_out_valid(d_out_valid), .d_out_ready(d_out_ready),
    .d_out_opcode(d_out_opcode), .d_out_param(d_out_param), .d_out_size(d_out_size),
    .d_out_source(d_out_source), .d_out_denied(d_out_denied), .d_out_corrupt(d_out_corrupt),
    .d_out_data(d_out_data),
    .a_level(a_level), .d_level(d_level)
  );

  // DEPTH=3 instance for the stress run
  tl_a_beat_t s_a_in, s_a_out;
  tl_d_beat_t s_d_in, s_d_out;
  logic s_a_in_valid, s_a_in_ready, s_a_out_valid, s_a_out_ready;
  logic s_d_in_valid, s_d_in_ready, s_d_out_valid, s_d_out_ready;
  logic [2:0] s_a_out_opcode, s_a_out_param, s_d_out_opcode;
  logic [1:0] s_a_out_size, s_a_out_source, s_d_out_param, s_d_out_size, s_d_out_source;
  logic [8:0] s_a_out_address;
  logic [3:0] s_a_out_mask;
  logic [31:0] s_a_out_data, s_d_out_data;
  logic s_a_out_corrupt, s_d_out_denied, s_d_out_corrupt;
  logic [1:0] s_a_level, s_d_level;

  assign s_a_out = {s_a_out_opcode, s_a_out_param, s_a_out_size, s_a_out_source,
                    s_a_out_address, s_a_out_mask, s_a_out_data, s_a_out_corrupt};
  assign s_d_out = {s_d_out_opcode, s_d_out_param, s_d_out_size, s_d_out_source,
                    s_d_out_denied, s_d_out_corrupt, s_d_out_data};

  periph_tl_buffer #(.DEPTH(3)) dut_stress (
    .clock(clock), .reset(reset),
    .a_in_valid(s_a_in_valid), .a_in_ready(s_a_in_ready),
    .a_in_opcode(s_a_in.opcode), .a_in_param(s_a_in.param), .a_in_size(s_a_in.size),
    .a_in_source(s_a_in.source), .a_in_address(s_a_in.address), .a_in_mask(s_a_in.mask),
    .a_in_data(s_a_in.data), .a_in_corrupt(s_a_in.corrupt),
    .a_out_valid(s_a_out_valid), .a_out_ready(s_a_out_ready),
    .a_out_opcode(s_a_out_opcode), .a_out_param(s_a_out_param), .a_out_size(s_a_out_size),
    .a_out_source(s_a_out_source), .a_out_address(s_a_out_address), .a_out_mask(s_a_out_mask),
    .a_out_data(s_a_out_data), .a_out_corrupt(s_a_out_corrupt),
    .d_in_valid(s_d_in_valid), .d_in_ready(s_d_in_ready),
    .d_in_opcode(s_d_in.opcode), .d_in_param(s_d_in.param), .d_in_size(s_d_in.size),
    .d_in_source(s_d_in.source), .d_in_denied(s_d_in.denied), .d_in_corrupt(s_d_in.corrupt),
    .d_in_data(s_d_in.data),
    .d_out_valid(s_d_out_valid), .d_out_ready(s_d_out_ready),
    .d_out_opcode(s_d_out_opcode), .d_out_param(s_d_out_param), .d_out_size(s_d_out_size),
    .d_out_source(s_d_out_source), .d_out_denied(s_d_out_denied), .d_out_corrupt(s_d_out_corrupt),
    .d_out_data(s_d_out_data),
    .a_level(s_a_level), .d_level(s_d_level)
  );

  typedef struct {
    logic       valid;
    logic       out_ready;
    logic [8:0] addr;
    logic       exp_in_ready;
    logic       exp_out_valid;
    logic [8:0] exp_addr;
    logic [1:0] exp_level;
  } vec_t;

  vec_t vecs[8];

  tl_a_beat_t sa_q[$];
  tl_d_beat_t sd_q[$];
  tl_a_beat_t a_prev;
  tl_d_beat_t d_prev;
  logic a_hold = 1'b0;
  logic d_hold = 1'b0;
  int a_sent = 0;
  int d_sent = 0;

  task automatic expectEq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int i);
    a_in_valid     = vecs[i].valid;
    a_out_ready    = vecs[i].out_ready;
    a_in           = '0;
    a_in.opcode    = TL_A_PUT_FULL;
    a_in.size      = 2'd2;
    a_in.mask      = 4'hF;
    a_in.address   = vecs[i].addr;
    a_in.data      = 32'hA000_0000 | {23'd0, vecs[i].addr};
  endtask

  task automatic checkOutput(input int i);
    expectEq($sformatf("row%0d a_in_ready", i), 64'(a_in_ready), 64'(vecs[i].exp_in_ready));
    expectEq($sformatf("row%0d a_out_valid", i), 64'(a_out_valid), 64'(vecs[i].exp_out_valid));
    expectEq($sformatf("row%0d a_level", i), 64'(a_level), 64'(vecs[i].exp_level));
    if (vecs[i].exp_out_valid) begin
      expectEq($sformatf("row%0d a_out_address", i), 64'(a_out_address), 64'(vecs[i].exp_addr));
      expectEq($sformatf("row%0d a_out_data", i), 64'(a_out_data),
               64'(32'hA000_0000 | {23'd0, vecs[i].exp_addr}));
    end
  endtask

  // One stress cycle on the DEPTH=3 instance; drive=0 drains with ready held high.
  task automatic stressCycle(input bit drive);
    logic [63:0] r;
    s_a_in_valid  = drive && (a_sent < BEATS) && ($urandom_range(0, 99) < 60);
    r             = {$urandom, $urandom};
    s_a_in        = r[$bits(tl_a_beat_t)-1:0];
    s_a_out_ready = !drive || ($urandom_range(0, 99) < 55);
    s_d_in_valid  = drive && (d_sent < BEATS) && ($urandom_range(0, 99) < 55);
    r             = {$urandom, $urandom};
    s_d_in        = r[$bits(tl_d_beat_t)-1:0];
    s_d_out_ready = !drive || ($urandom_range(0, 99) < 60);
    #1;
    expectEq("s_a_level", 64'(s_a_level), 64'(sa_q.size()));
    expectEq("s_d_level", 64'(s_d_level), 64'(sd_q.size()));
    expectEq("s_a_in_ready", 64'(s_a_in_ready), 64'(sa_q.size() != 3));
    expectEq("s_d_in_ready", 64'(s_d_in_ready), 64'(sd_q.size() != 3));
    if (a_hold) expectEq("s_a_stable", 64'({s_a_out_valid, s_a_out}), 64'({1'b1, a_prev}));
    if (d_hold) expectEq("s_d_stable", 64'({s_d_out_valid, s_d_out}), 64'({1'b1, d_prev}));
    if (s_a_out_valid && s_a_out_ready) begin
      if (sa_q.size() == 0) begin
        checks++; fails++;
        $display("[TB] FAIL s_a_pop: got a beat, expected empty queue");
      end else expectEq("s_a_order", 64'(s_a_out), 64'(sa_q.pop_front()));
    end
    if (s_d_out_valid && s_d_out_ready) begin
      if (sd_q.size() == 0) begin
        checks++; fails++;
        $display("[TB] FAIL s_d_pop: got a beat, expected empty queue");
      end else expectEq("s_d_order", 64'(s_d_out), 64'(sd_q.pop_front()));
    end
    if (s_a_in_valid && s_a_in_ready) begin
      sa_q.push_back(s_a_in);
      a_sent++;
    end
    if (s_d_in_valid && s_d_in_ready) begin
      sd_q.push_back(s_d_in);
      d_sent++;
    end
    a_hold = s_a_out_valid && !s_a_out_ready;
    d_hold = s_d_out_valid && !s_d_out_ready;
    a_prev = s_a_out;
    d_prev = s_d_out;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int cyc;
    // A channel: fill past full, drain, and overlap push/pop at level 1.
    vecs[0] = '{1'b1, 1'b0, 9'h010, 1'b1, 1'b0, 9'h000, 2'd0};
    vecs[1] = '{1'b1, 1'b0, 9'h020, 1'b1, 1'b1, 9'h010, 2'd1};
    vecs[2] = '{1'b1, 1'b0, 9'h030, 1'b0, 1'b1, 9'h010, 2'd2};
    vecs[3] = '{1'b1, 1'b1, 9'h030, 1'b0, 1'b1, 9'h010, 2'd2};
    vecs[4] = '{1'b1, 1'b1, 9'h030, 1'b1, 1'b1, 9'h020, 2'd1};
    vecs[5] = '{1'b0, 1'b0, 9'h000, 1'b1, 1'b1, 9'h030, 2'd1};
    vecs[6] = '{1'b0, 1'b1, 9'h000, 1'b1, 1'b1, 9'h030, 2'd1};
    vecs[7] = '{1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 9'h000, 2'd0};

    reset = 1'b1;
    a_in = '0; d_in = '0; s_a_in = '0; s_d_in = '0;
    a_in_valid = 0; a_out_ready = 0; d_in_valid = 0; d_out_ready = 0;
    s_a_in_valid = 0; s_a_out_ready = 0; s_d_in_valid = 0; s_d_out_ready = 0;
    #12;
    expectEq("rst a_in_ready", 64'(a_in_ready), 64'd1);
    expectEq("rst d_in_ready", 64'(d_in_ready), 64'd1);
    expectEq("rst a_out_valid", 64'(a_out_valid), 64'd0);
    expectEq("rst d_out_valid", 64'(d_out_valid), 64'd0);
    expectEq("rst a_level", 64'(a_level), 64'd0);
    expectEq("rst d_level", 64'(d_level), 64'd0);
    expectEq("rst s_a_in_ready", 64'(s_a_in_ready), 64'd1);
    expectEq("rst s_d_out_valid", 64'(s_d_out_valid), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(i);
      #2;
      checkOutput(i);
      @(posedge clock);
      #1;
    end
    a_in_valid = 0;
    a_out_ready = 0;

    // D channel: two denied AccessAckData beats, then reset discards them.
    d_in = '{opcode: TL_D_ACCESS_ACK_DATA, param: 2'd0, size: 2'd2, source: 2'd1,
             denied: 1'b1, corrupt: 1'b0, data: 32'hDEAD_BEEF};
    d_in_valid = 1;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    d_in_valid = 0;
    #1;
    expectEq("d full level", 64'(d_level), 64'd2);
    expectEq("d full in_ready", 64'(d_in_ready), 64'd0);
    expectEq("d head valid", 64'(d_out_valid), 64'd1);
    expectEq("d head data", 64'(d_out_data), 64'hDEAD_BEEF);
    expectEq("d head denied", 64'(d_out_denied), 64'd1);
    expectEq("d head opcode", 64'(d_out_opcode), 64'(TL_D_ACCESS_ACK_DATA));
    expectEq("d head source", 64'(d_out_source), 64'd1);
    reset = 1'b1;
    #1;
    expectEq("async rst d_out_valid", 64'(d_out_valid), 64'd0);
    expectEq("async rst d_level", 64'(d_level), 64'd0);
    expectEq("async rst d_in_ready", 64'(d_in_ready), 64'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    d_out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      expectEq($sformatf("post rst d_out_valid c%0d", i), 64'(d_out_valid), 64'd0);
      expectEq($sformatf("post rst d_level c%0d", i), 64'(d_level), 64'd0);
      @(posedge clock);
      #1;
    end

    // Handshake presented while reset is released must land normally.
    d_out_ready = 0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    d_in.data = 32'h1234_5678;
    d_in.denied = 1'b0;
    d_in_valid = 1;
    @(posedge clock);
    #1;
    d_in_valid = 0;
    #1;
    expectEq("deassert d_level", 64'(d_level), 64'd1);
    expectEq("deassert d_out_data", 64'(d_out_data), 64'h1234_5678);
    expectEq("deassert d_out_denied", 64'(d_out_denied), 64'd0);
    d_out_ready = 1;
    @(posedge clock);
    #1;
    expectEq("deassert drained", 64'(d_level), 64'd0);
    d_out_ready = 0;

    // Random stress on the DEPTH=3 instance.
    cyc = 0;
    while ((a_sent < BEATS || d_sent < BEATS) && cyc < MAX_CYCLE) begin
      stressCycle(1'b1);
      cyc++;
    end
    if (cyc >= MAX_CYCLE) begin
      checks++;
      fails++;
      $display("[TB] FAIL stress_timeout: sent a=%0d d=%0d, required %0d each", a_sent, d_sent, BEATS);
    end
    repeat (6) stressCycle(1'b0);
    expectEq("s_a_drained", 64'(sa_q.size()), 64'd0);
    expectEq("s_d_drained", 64'(sd_q.size()), 64'd0);
    expectEq("s_a_level_end", 64'(s_a_level), 64'd0);
    expectEq("s_d_level_end", 64'(s_d_level), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
